// File: rtl/sign_extension_pkg.sv
// Shared types and helpers for the sign/zero width extender.
`timescale 1ns/1ps

package sign_extension_pkg;

  // Extension mode: replicate the MSB or fill the upper bits with zeros.
  typedef enum logic {
    EXT_SIGN = 1'b0,
    EXT_ZERO = 1'b1
  } ext_mode_e;

  // Fill bit for the upper part of the widened result. An unknown msb or
  // mode deliberately propagates as X instead of being cleaned up.
  function automatic logic ext_upper(input logic msb, input ext_mode_e mode);
    return (mode == EXT_ZERO) ? 1'b0 : msb;
  endfunction

endpackage

// File: rtl/sign_extension_if.sv
// Bus bundle between a narrow producer and the width extender.
`timescale 1ns/1ps

interface sign_extension_if #(
  parameter int InputWidth  = 8,
  parameter int OutputWidth = 16
);

  logic signed [InputWidth-1:0]  in;
  logic                          in_valid;
  logic                          zero_ext;
  logic signed [OutputWidth-1:0] out;
  logic signed [OutputWidth-1:0] out_q;
  logic                          out_q_valid;

  // Producer side: drives the narrow value and mode, observes both results.
  modport master (
    output in, in_valid, zero_ext,
    input  out, out_q, out_q_valid
  );

  // Extender side: consumes the narrow value, produces both results.
  modport slave (
    input  in, in_valid, zero_ext,
    output out, out_q, out_q_valid
  );

endinterface

// File: rtl/sign_extension_core.sv
// Purely combinational widening of an InputWidth value to OutputWidth bits.
`timescale 1ns/1ps

module sign_ext_core
  import sign_extension_pkg::*;
#(
  parameter int InputWidth  = 8,
  parameter int OutputWidth = 16
) (
  input  logic signed [InputWidth-1:0]  in,
  input  logic                          zero_ext,
  output logic signed [OutputWidth-1:0] out
);

  if (OutputWidth > InputWidth) begin : g_widen
    logic fill;

    // Pick the replicated bit, then place it above the untouched input bits.
    always_comb begin
      fill = ext_upper(in[InputWidth-1], ext_mode_e'(zero_ext));
      out  = {{(OutputWidth - InputWidth){fill}}, in};
    end
  end else if (OutputWidth == InputWidth) begin : g_pass
    // No upper bits exist, so both modes reduce to a plain copy.
    always_comb begin
      out = in;
    end
  end else begin : g_invalid
    // Illegal narrowing configuration; the top level rejects it at elaboration.
    always_comb begin
      out = '0;
    end
  end

endmodule

// File: rtl/sign_extension.sv
// Width extender top: combinational result plus a valid-qualified register stage.
`timescale 1ns/1ps

module sign_extension
  import sign_extension_pkg::*;
#(
  parameter int InputWidth  = 8,
  parameter int OutputWidth = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  sign_extension_if.slave bus
);

  if (InputWidth < 1) begin : g_bad_input_width
    $error("sign_extension: InputWidth must be at least 1");
  end

  if (OutputWidth < InputWidth) begin : g_bad_output_width
    $error("sign_extension: OutputWidth must be >= InputWidth, truncation is not supported");
  end

  logic signed [OutputWidth-1:0] ext_out;
  logic signed [OutputWidth-1:0] data_d;
  logic signed [OutputWidth-1:0] data_q;
  logic                          valid_d;
  logic                          valid_q;

  sign_ext_core #(
    .InputWidth (InputWidth),
    .OutputWidth(OutputWidth)
  ) u_core (
    .in      (bus.in),
    .zero_ext(bus.zero_ext),
    .out     (ext_out)
  );

  // Capture the extension on valid beats; hold data otherwise while valid drops.
  always_comb begin
    data_d  = data_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      data_d = ext_out;
    end
  end

  // Output register stage; reset discards any in-flight result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out         = ext_out;
  assign bus.out_q       = data_q;
  assign bus.out_q_valid = valid_q;

endmodule

// File: tb/tb_sign_extension.sv
// Directed self-checking bench for the sign/zero width extender.
`timescale 1ns/1ps

module tb_sign_extension;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  int   fails;

  sign_extension_if #(.InputWidth(8), .OutputWidth(16)) bif ();
  sign_extension_if #(.InputWidth(8), .OutputWidth(8))  bif_eq ();
  sign_extension_if #(.InputWidth(1), .OutputWidth(16)) bif_w1 ();

  sign_extension #(.InputWidth(8), .OutputWidth(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  sign_extension #(.InputWidth(8), .OutputWidth(8)) dut_eq (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif_eq)
  );

  sign_extension #(.InputWidth(1), .OutputWidth(16)) dut_w1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif_w1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the main 8->16 instance inputs.
  task automatic applyStimulus(input logic [7:0] value, input logic mode, input logic valid);
    bif.in       = value;
    bif.zero_ext = mode;
    bif.in_valid = valid;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Linear directed sequence covering combinational, registered and reset behaviour.
  initial begin
    checks = 0;
    passes = 0;
    fails  = 0;
    rst_n  = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);
    bif_eq.in       = 8'h00;
    bif_eq.zero_ext = 1'b0;
    bif_eq.in_valid = 1'b0;
    bif_w1.in       = 1'b0;
    bif_w1.zero_ext = 1'b0;
    bif_w1.in_valid = 1'b0;

    #1;
    checkOutput("reset_out_q", bif.out_q, 16'h0000);
    checkOutput("reset_out_q_valid", {15'd0, bif.out_q_valid}, 16'h0000);

    // Combinational sign mode, 10 time units apart.
    applyStimulus(8'h7F, 1'b0, 1'b0); #10;
    checkOutput("sign_7F", bif.out, 16'h007F);
    applyStimulus(8'h80, 1'b0, 1'b0); #10;
    checkOutput("sign_80", bif.out, 16'hFF80);
    applyStimulus(8'h00, 1'b0, 1'b0); #10;
    checkOutput("sign_00", bif.out, 16'h0000);
    applyStimulus(8'h01, 1'b0, 1'b0); #10;
    checkOutput("sign_01", bif.out, 16'h0001);
    applyStimulus(8'hF0, 1'b0, 1'b0); #10;
    checkOutput("sign_F0", bif.out, 16'hFFF0);

    // Zero mode and mode toggling without any clock dependence.
    applyStimulus(8'h80, 1'b1, 1'b0); #10;
    checkOutput("zero_80", bif.out, 16'h0080);
    applyStimulus(8'hF0, 1'b1, 1'b0); #10;
    checkOutput("zero_F0", bif.out, 16'h00F0);
    applyStimulus(8'h80, 1'b0, 1'b0); #1;
    checkOutput("toggle_sign", bif.out, 16'hFF80);
    bif.zero_ext = 1'b1; #1;
    checkOutput("toggle_zero", bif.out, 16'h0080);
    bif.zero_ext = 1'b0; #1;
    checkOutput("toggle_back", bif.out, 16'hFF80);
    checkOutput("in_reset_out_q", bif.out_q, 16'h0000);

    // Registered path: capture, then hold with valid dropped.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h80, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("reg_capture_data", bif.out_q, 16'hFF80);
    checkOutput("reg_capture_valid", {15'd0, bif.out_q_valid}, 16'h0001);
    @(negedge clk);
    applyStimulus(8'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("reg_hold_data", bif.out_q, 16'hFF80);
    checkOutput("reg_hold_valid", {15'd0, bif.out_q_valid}, 16'h0000);

    // Async reset between edges clears the register but not the comb path.
    @(negedge clk);
    applyStimulus(8'hF0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("pre_reset_data", bif.out_q, 16'hFFF0);
    checkOutput("pre_reset_valid", {15'd0, bif.out_q_valid}, 16'h0001);
    @(negedge clk);
    applyStimulus(8'h7F, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_data", bif.out_q, 16'h0000);
    checkOutput("async_reset_valid", {15'd0, bif.out_q_valid}, 16'h0000);
    checkOutput("async_reset_comb", bif.out, 16'h007F);
    @(posedge clk); #1;
    checkOutput("reset_held_valid", {15'd0, bif.out_q_valid}, 16'h0000);

    // Back-to-back valid stream after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h7F, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("b2b_0_data", bif.out_q, 16'h007F);
    checkOutput("b2b_0_valid", {15'd0, bif.out_q_valid}, 16'h0001);
    @(negedge clk);
    applyStimulus(8'h80, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("b2b_1_data", bif.out_q, 16'hFF80);
    checkOutput("b2b_1_valid", {15'd0, bif.out_q_valid}, 16'h0001);
    @(negedge clk);
    applyStimulus(8'h01, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("b2b_2_data", bif.out_q, 16'h0001);
    checkOutput("b2b_2_valid", {15'd0, bif.out_q_valid}, 16'h0001);

    // Registered zero mode honoured on the same edge as the mode change.
    @(negedge clk);
    applyStimulus(8'h80, 1'b1, 1'b1);
    @(posedge clk); #1;
    checkOutput("reg_zero_data", bif.out_q, 16'h0080);
    @(negedge clk);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // Parameter edge: equal widths pass the input straight through.
    bif_eq.in = 8'h80; bif_eq.zero_ext = 1'b0; #1;
    checkOutput("eq_sign_80", {8'd0, bif_eq.out}, 16'h0080);
    bif_eq.zero_ext = 1'b1; #1;
    checkOutput("eq_zero_80", {8'd0, bif_eq.out}, 16'h0080);

    // Parameter edge: single-bit input.
    bif_w1.in = 1'b1; bif_w1.zero_ext = 1'b0; #1;
    checkOutput("w1_sign_1", bif_w1.out, 16'hFFFF);
    bif_w1.zero_ext = 1'b1; #1;
    checkOutput("w1_zero_1", bif_w1.out, 16'h0001);
    bif_w1.in = 1'b0; bif_w1.zero_ext = 1'b0; #1;
    checkOutput("w1_sign_0", bif_w1.out, 16'h0000);

    #10;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
